floor_scheduler: RTL and testbench

//  Sequences the scrolling-floor datapath for the game. Runs the game-state FSM (IDLE/PLAY/OVER).

---
 rtl/floor_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/floor_scheduler.sv | 142 ++++++++++++++
 tb/tb_floor_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
// Shared types and screen/floor geometry for the scrolling-floor scheduler.
// The helper folds a 10-bit LFSR value into a respawn column below a limit.
package floor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } game_state_t;

    localparam int NUM_FLOORS = 5;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int FLOOR_W    = 90;
    localparam int FLOOR_H    = 20;

    // A single subtraction is enough because 1023 - lim < lim for any lim >= 512.
    function automatic logic [9:0] wrap_x(input logic [9:0] v, input logic [9:0] lim);
        return (v >= lim) ? (v - lim) : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cur;
    logic [IW-1:0] gnt_idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        cur     = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[cur]) begin
                found    = 1'b1;
                gnt[cur] = 1'b1;
                gnt_idx  = cur;
            end
            cur = (cur == LAST) ? '0 : cur + 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/floor_scheduler.sv
// Game-state FSM, frame-synchronous scroll tick/step generation and
// round-robin floor respawn grants carrying an LFSR-derived X position.
module floor_scheduler
    import floor_pkg::*;
#(
    parameter int          NUM_FLOORS    = floor_pkg::NUM_FLOORS,
    parameter int          SCROLL_DIV    = 1,
    parameter int          MAX_STEP      = 4,
    parameter int          RESPAWN_X_MAX = 550,
    parameter logic [9:0]  LFSR_SEED     = 10'h1AB
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  start,
    input  logic                  player_dead,
    input  logic [3:0]            score1,
    input  logic [3:0]            score0,
    input  logic [NUM_FLOORS-1:0] respawn_req,
    output logic [NUM_FLOORS-1:0] respawn_gnt,
    output logic [9:0]            respawn_x,
    output logic                  scroll_tick,
    output logic [9:0]            floor_step,
    output logic [1:0]            game_state
);

    localparam int            DW       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);
    localparam logic [9:0]    STEP_CAP = 10'(MAX_STEP);
    localparam logic [9:0]    X_LIMIT  = 10'(RESPAWN_X_MAX);

    game_state_t           state_q, state_d;
    logic                  in_play, stay_play;
    logic                  frame_clk_d_q, frame_rise;
    logic [DW-1:0]         div_q, div_d;
    logic                  tick_q, tick_d;
    logic [3:0]            score_sat;
    logic [9:0]            step_raw;
    logic [9:0]            step_q, step_d;
    logic [9:0]            lfsr_q, lfsr_d;
    logic [NUM_FLOORS-1:0] gnt_q, arb_req, arb_gnt;
    logic [9:0]            x_q, x_d;
    logic                  score0_unused;

    // The units digit does not influence scrolling speed.
    assign score0_unused = ^score0;

    assign frame_rise = frame_clk & ~frame_clk_d_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_PLAY : ST_IDLE;
            ST_PLAY: state_d = player_dead ? ST_OVER : ST_PLAY;
            ST_OVER: state_d = start ? ST_IDLE : ST_OVER;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ticks and grants are only issued when the next cycle is still PLAY,
    // so neither output can ever be observed outside PLAY.
    always_comb begin
        game_state = state_q;
        in_play    = (state_q == ST_PLAY);
        stay_play  = in_play && (state_d == ST_PLAY);
    end

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (!in_play) begin
            div_d = '0;
        end else if (frame_rise) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = stay_play;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_comb begin
        score_sat = (score1 > 4'd9) ? 4'd9 : score1;
        step_raw  = 10'd1 + {7'd0, score_sat[3:1]};
        step_d    = step_q;
        if (!in_play) begin
            step_d = 10'd1;
        end else if (frame_rise) begin
            step_d = (step_raw > STEP_CAP) ? STEP_CAP : step_raw;
        end
    end

    assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    // Masking the slot granted last cycle keeps a late-dropping requester
    // from winning twice in a row.
    assign arb_req = stay_play ? (respawn_req & ~gnt_q) : '0;
    assign x_d     = (arb_gnt != '0) ? wrap_x(lfsr_q, X_LIMIT) : 10'd0;

    rr_arbiter #(.N(NUM_FLOORS)) u_arb (
        .clk  (Clk),
        .srst (Reset),
        .en   (stay_play),
        .req  (arb_req),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d_q <= 1'b0;
            div_q         <= '0;
            tick_q        <= 1'b0;
            step_q        <= 10'd1;
            lfsr_q        <= LFSR_SEED;
            gnt_q         <= '0;
            x_q           <= 10'd0;
        end else begin
            frame_clk_d_q <= frame_clk;
            div_q         <= div_d;
            tick_q        <= tick_d;
            step_q        <= step_d;
            lfsr_q        <= lfsr_d;
            gnt_q         <= arb_gnt;
            x_q           <= x_d;
        end
    end

    assign respawn_gnt = gnt_q;
    assign respawn_x   = x_q;
    assign scroll_tick = tick_q;
    assign floor_step  = step_q;

endmodule

// File: tb/tb_floor_scheduler.sv
// Directed and soak checks for floor_scheduler with SCROLL_DIV=1 and SCROLL_DIV=3.
module tb_floor_scheduler;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       start = 1'b0;
    logic       player_dead = 1'b0;
    logic [3:0] score1 = 4'd0;
    logic [3:0] score0 = 4'd0;
    logic [4:0] respawn_req = 5'd0;

    logic [4:0] respawn_gnt, gnt3;
    logic [9:0] respawn_x, x3;
    logic       scroll_tick, tick3;
    logic [9:0] floor_step, step3;
    logic [1:0] game_state, state3;

    int errors = 0;
    int checks = 0;

    floor_scheduler #(.SCROLL_DIV(1)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .player_dead(player_dead), .score1(score1), .score0(score0),
        .respawn_req(respawn_req), .respawn_gnt(respawn_gnt), .respawn_x(respawn_x),
        .scroll_tick(scroll_tick), .floor_step(floor_step), .game_state(game_state)
    );

    floor_scheduler #(.SCROLL_DIV(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .player_dead(player_dead), .score1(score1), .score0(score0),
        .respawn_req(respawn_req), .respawn_gnt(gnt3), .respawn_x(x3),
        .scroll_tick(tick3), .floor_step(step3), .game_state(state3)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step_clk();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step_clk();
        step_clk();
        Reset = 1'b0;
        step_clk();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        checks++;
        if (game_state !== 2'b01) begin
            errors++; $display("FAIL pre_reset_play: state=%b expected 01", game_state);
        end
        // Request and frame edge pending when reset hits
        respawn_req = 5'b00001;
        frame_clk   = 1'b1;
        Reset       = 1'b1;
        step_clk();
        checks++;
        if (game_state !== 2'b00) begin
            errors++; $display("FAIL reset_state: state=%b expected 00", game_state);
        end
        checks++;
        if (respawn_gnt !== 5'b0) begin
            errors++; $display("FAIL reset_gnt: gnt=%b expected 00000", respawn_gnt);
        end
        checks++;
        if (scroll_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: tick=%b expected 0", scroll_tick);
        end
        checks++;
        if (floor_step !== 10'd1) begin
            errors++; $display("FAIL reset_step: step=%0d expected 1", floor_step);
        end
        checks++;
        if (respawn_x !== 10'd0) begin
            errors++; $display("FAIL reset_x: x=%0d expected 0", respawn_x);
        end
        checks++;
        if (dut.lfsr_q !== 10'h1AB) begin
            errors++; $display("FAIL reset_lfsr: lfsr=%h expected 1ab", dut.lfsr_q);
        end
        Reset       = 1'b0;
        respawn_req = 5'b0;
        frame_clk   = 1'b0;
        step_clk();
        $display("reset: state=%b gnt=%b step=%0d", game_state, respawn_gnt, floor_step);
    endtask

    task automatic test_start();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        checks++;
        if (game_state !== 2'b01) begin
            errors++; $display("FAIL start_play: state=%b expected 01", game_state);
        end
        checks++;
        if (floor_step !== 10'd1) begin
            errors++; $display("FAIL start_step: step=%0d expected 1", floor_step);
        end
        $display("start: state=%b step=%0d", game_state, floor_step);
    endtask

    task automatic test_scroll();
        score1 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            frame_clk = 1'b1;
            step_clk();
            checks++;
            if (scroll_tick !== 1'b1) begin
                errors++; $display("FAIL tick_div1_%0d: tick=%b expected 1", i, scroll_tick);
            end
            checks++;
            if (tick3 !== (i == 2)) begin
                errors++; $display("FAIL tick_div3_%0d: tick=%b expected %b", i, tick3, (i == 2));
            end
            step_clk();
            checks++;
            if (scroll_tick !== 1'b0 || tick3 !== 1'b0) begin
                errors++; $display("FAIL tick_width_%0d: tick=%b tick3=%b expected 0 0", i, scroll_tick, tick3);
            end
            frame_clk = 1'b0;
            step_clk();
            $display("frame %0d: tick1 ok, tick3=%b", i, tick3);
        end
    endtask

    task automatic test_step();
        logic [3:0] sc  [4] = '{4'd0, 4'd3, 4'd6, 4'd9};
        logic [9:0] exp [4] = '{10'd1, 10'd2, 10'd4, 10'd4};
        for (int i = 0; i < 4; i++) begin
            score1    = sc[i];
            frame_clk = 1'b1;
            step_clk();
            checks++;
            if (floor_step !== exp[i]) begin
                errors++; $display("FAIL step_score%0d: step=%0d expected %0d", sc[i], floor_step, exp[i]);
            end
            frame_clk = 1'b0;
            step_clk();
            $display("score1=%0d -> step=%0d", sc[i], floor_step);
        end
        score1 = 4'd0;
        step_clk();
        step_clk();
        checks++;
        if (floor_step !== 10'd4) begin
            errors++; $display("FAIL step_stable: step=%0d expected 4", floor_step);
        end
    endtask

    task automatic test_arbiter();
        logic [4:0] exp [8] = '{5'b00001, 5'b00100, 5'b10000, 5'b00000,
                                5'b00010, 5'b00000, 5'b00010, 5'b00001};
        respawn_req = 5'b10101;
        for (int i = 0; i < 4; i++) begin
            step_clk();
            checks++;
            if (respawn_gnt !== exp[i]) begin
                errors++; $display("FAIL rr_grant_%0d: gnt=%b expected %b", i, respawn_gnt, exp[i]);
            end
            checks++;
            if (respawn_gnt != 5'b0 && respawn_x >= 10'd550) begin
                errors++; $display("FAIL rr_x_%0d: x=%0d expected <550", i, respawn_x);
            end
            $display("grant %0d: gnt=%b x=%0d", i, respawn_gnt, respawn_x);
            respawn_req = respawn_req & ~respawn_gnt;
        end
        // Held request: masked for one cycle, then a fresh grant
        respawn_req = 5'b00010;
        for (int i = 4; i < 7; i++) begin
            step_clk();
            checks++;
            if (respawn_gnt !== exp[i]) begin
                errors++; $display("FAIL hold_grant_%0d: gnt=%b expected %b", i, respawn_gnt, exp[i]);
            end
            $display("grant %0d: gnt=%b", i, respawn_gnt);
        end
        // Pointer at 2, slot 1 masked: wraps to slot 0
        respawn_req = 5'b00011;
        step_clk();
        checks++;
        if (respawn_gnt !== exp[7]) begin
            errors++; $display("FAIL wrap_grant: gnt=%b expected %b", respawn_gnt, exp[7]);
        end
        respawn_req = 5'b00010;
        step_clk();
        checks++;
        if (respawn_gnt !== 5'b00010) begin
            errors++; $display("FAIL wrap_next: gnt=%b expected 00010", respawn_gnt);
        end
        respawn_req = 5'b0;
        step_clk();
        $display("wrap: done");
    endtask

    task automatic test_state();
        start = 1'b1;
        player_dead = 1'b1;
        step_clk();
        checks++;
        if (game_state !== 2'b10) begin
            errors++; $display("FAIL dead_wins: state=%b expected 10", game_state);
        end
        start = 1'b0;
        player_dead = 1'b0;
        respawn_req = 5'b00100;
        frame_clk = 1'b1;
        step_clk();
        checks++;
        if (game_state !== 2'b10 || respawn_gnt !== 5'b0 || scroll_tick !== 1'b0) begin
            errors++; $display("FAIL over_quiet: state=%b gnt=%b tick=%b expected 10 00000 0",
                               game_state, respawn_gnt, scroll_tick);
        end
        frame_clk = 1'b0;
        respawn_req = 5'b0;
        start = 1'b1;
        step_clk();
        checks++;
        if (game_state !== 2'b00) begin
            errors++; $display("FAIL over_to_idle: state=%b expected 00", game_state);
        end
        start = 1'b0;
        step_clk();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        checks++;
        if (game_state !== 2'b01) begin
            errors++; $display("FAIL idle_to_play: state=%b expected 01", game_state);
        end
        step_clk();
        checks++;
        if (respawn_gnt !== 5'b0) begin
            errors++; $display("FAIL req_not_latched: gnt=%b expected 00000", respawn_gnt);
        end
        $display("state walk: PLAY->OVER->IDLE->PLAY state=%b", game_state);
    endtask

    task automatic test_soak();
        logic [9:0] prev_lfsr, exp_lfsr, exp_x;
        logic [4:0] prev_gnt;
        prev_lfsr = dut.lfsr_q;
        prev_gnt  = respawn_gnt;
        for (int c = 0; c < 2000; c++) begin
            respawn_req = (respawn_req | 5'($urandom_range(0, 31))) & ~respawn_gnt;
            start       = ($urandom_range(0, 39) == 0);
            player_dead = ($urandom_range(0, 59) == 0);
            score1      = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            step_clk();
            exp_lfsr = {prev_lfsr[8:0], prev_lfsr[9] ^ prev_lfsr[6]};
            exp_x    = (prev_lfsr >= 10'd550) ? prev_lfsr - 10'd550 : prev_lfsr;
            checks++;
            if (dut.lfsr_q === 10'd0 || dut.lfsr_q !== exp_lfsr) begin
                errors++; $display("FAIL soak_lfsr c=%0d: lfsr=%h expected %h", c, dut.lfsr_q, exp_lfsr);
            end
            checks++;
            if (respawn_gnt != 5'b0 && (respawn_x >= 10'd550 || respawn_x !== exp_x)) begin
                errors++; $display("FAIL soak_x c=%0d: x=%0d expected %0d", c, respawn_x, exp_x);
            end
            checks++;
            if (!$onehot0(respawn_gnt) || (respawn_gnt & prev_gnt) != 5'b0) begin
                errors++; $display("FAIL soak_gnt c=%0d: gnt=%b prev=%b expected one-hot, no repeat",
                                   c, respawn_gnt, prev_gnt);
            end
            checks++;
            if (game_state != 2'b01 && (respawn_gnt != 5'b0 || scroll_tick || tick3)) begin
                errors++; $display("FAIL soak_idle_quiet c=%0d: state=%b gnt=%b tick=%b tick3=%b expected no activity",
                                   c, game_state, respawn_gnt, scroll_tick, tick3);
            end
            checks++;
            if (game_state === 2'b11) begin
                errors++; $display("FAIL soak_state c=%0d: state=11 expected legal", c);
            end
            prev_lfsr = dut.lfsr_q;
            prev_gnt  = respawn_gnt;
        end
        respawn_req = 5'b0;
        start = 1'b0;
        player_dead = 1'b0;
        $display("soak: 2000 cycles done");
    endtask

    initial begin
        test_reset();
        test_start();
        test_scroll();
        test_step();
        test_arbiter();
        test_state();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
